// File: rtl/ram_host_loader.sv
// Host byte-stream loader/dumper for the RV32Core debug BRAM ports.
// A 3-byte header selects load, dump or a timed core reset.
module ram_host_loader #(
    parameter int BRAM_WORDS       = 4096,
    parameter int RST_PULSE_CYCLES = 5
) (
    input  logic        CPU_CLK,
    input  logic        CPU_RST,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] DataRAM_A2,
    output logic [31:0] DataRAM_WD2,
    output logic [3:0]  DataRAM_WE2,
    input  logic [31:0] DataRAM_RD2,
    output logic [31:0] InstRAM_A2,
    output logic [31:0] InstRAM_WD2,
    output logic [3:0]  InstRAM_WE2,
    input  logic [31:0] InstRAM_RD2,
    output logic        core_rst,
    output logic        busy,
    output logic        err
);
    localparam logic [7:0] CMD_LD_DATA = 8'h01;
    localparam logic [7:0] CMD_LD_INST = 8'h02;
    localparam logic [7:0] CMD_DP_DATA = 8'h11;
    localparam logic [7:0] CMD_DP_INST = 8'h12;
    localparam logic [7:0] CMD_RESET   = 8'h20;

    localparam int          PW      = (RST_PULSE_CYCLES > 1) ? $clog2(RST_PULSE_CYCLES) : 1;
    localparam logic [16:0] MAX_CNT = 17'(BRAM_WORDS);

    typedef enum logic [3:0] {
        IDLE, HDR_LO, HDR_HI, LOAD_BYTE, LOAD_WR,
        DUMP_RD, DUMP_WAIT, DUMP_TX, RST_PULSE
    } stateT;

    stateT          state;
    logic [7:0]     cmd;
    logic [7:0]     cntLo;
    logic [15:0]    cnt;
    logic [12:0]    wordIdx;
    logic [1:0]     byteIdx;
    logic [23:0]    asmWord;
    logic [31:0]    rdWord;
    logic [PW-1:0]  pulseCnt;
    logic           rdyEn;

    logic        rxFire;
    logic        selInst;
    logic        lastWord;
    logic [31:0] rdSel;
    logic [31:0] wordAddr;
    logic [31:0] nextAddr;

    // cmd bit 1 picks the instruction BRAM for both load and dump commands
    assign selInst  = cmd[1];
    assign rdSel    = selInst ? InstRAM_RD2 : DataRAM_RD2;
    assign lastWord = (({3'b000, wordIdx}) + 16'd1) == cnt;
    assign wordAddr = {17'b0, wordIdx, 2'b00};
    assign nextAddr = {17'b0, wordIdx + 13'd1, 2'b00};

    // rdyEn keeps rx_ready low through reset and its release cycle
    assign rx_ready = rdyEn && (state inside {IDLE, HDR_LO, HDR_HI, LOAD_BYTE});
    assign tx_valid = (state == DUMP_TX);
    assign busy     = (state != IDLE);
    assign rxFire   = rx_valid && rx_ready;

    always_ff @(posedge CPU_CLK) begin
        if (CPU_RST) begin
            state       <= IDLE;
            cmd         <= 8'h00;
            cntLo       <= 8'h00;
            cnt         <= 16'h0000;
            wordIdx     <= 13'd0;
            byteIdx     <= 2'd0;
            asmWord     <= 24'h0;
            rdWord      <= 32'h0;
            pulseCnt    <= '0;
            rdyEn       <= 1'b0;
            tx_data     <= 8'h00;
            DataRAM_A2  <= 32'h0;
            DataRAM_WD2 <= 32'h0;
            DataRAM_WE2 <= 4'h0;
            InstRAM_A2  <= 32'h0;
            InstRAM_WD2 <= 32'h0;
            InstRAM_WE2 <= 4'h0;
            core_rst    <= 1'b1;
            err         <= 1'b0;
        end else begin
            rdyEn       <= 1'b1;
            core_rst    <= 1'b0;
            DataRAM_WE2 <= 4'h0;
            InstRAM_WE2 <= 4'h0;
            case (state)
                IDLE: begin
                    if (rxFire) begin
                        if (rx_data inside {CMD_LD_DATA, CMD_LD_INST, CMD_DP_DATA,
                                            CMD_DP_INST, CMD_RESET}) begin
                            cmd   <= rx_data;
                            err   <= 1'b0;
                            state <= HDR_LO;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                HDR_LO: begin
                    if (rxFire) begin
                        cntLo <= rx_data;
                        state <= HDR_HI;
                    end
                end
                HDR_HI: begin
                    if (rxFire) begin
                        cnt     <= {rx_data, cntLo};
                        wordIdx <= 13'd0;
                        byteIdx <= 2'd0;
                        if (cmd == CMD_RESET) begin
                            core_rst <= 1'b1;
                            pulseCnt <= PW'(RST_PULSE_CYCLES - 1);
                            state    <= RST_PULSE;
                        end else if ({1'b0, rx_data, cntLo} > MAX_CNT) begin
                            err   <= 1'b1;
                            state <= IDLE;
                        end else if ({rx_data, cntLo} == 16'h0000) begin
                            state <= IDLE;
                        end else if (cmd[4]) begin
                            state <= DUMP_RD;
                        end else begin
                            state <= LOAD_BYTE;
                        end
                    end
                end
                LOAD_BYTE: begin
                    if (rxFire) begin
                        byteIdx <= byteIdx + 2'd1;
                        case (byteIdx)
                            2'd0: asmWord[7:0]   <= rx_data;
                            2'd1: asmWord[15:8]  <= rx_data;
                            2'd2: asmWord[23:16] <= rx_data;
                            default: begin
                                if (selInst) begin
                                    InstRAM_WE2 <= 4'hF;
                                    InstRAM_A2  <= wordAddr;
                                    InstRAM_WD2 <= {rx_data, asmWord};
                                end else begin
                                    DataRAM_WE2 <= 4'hF;
                                    DataRAM_A2  <= wordAddr;
                                    DataRAM_WD2 <= {rx_data, asmWord};
                                end
                                state <= LOAD_WR;
                            end
                        endcase
                    end
                end
                LOAD_WR: begin
                    wordIdx <= wordIdx + 13'd1;
                    if (lastWord) begin
                        DataRAM_A2  <= 32'h0;
                        DataRAM_WD2 <= 32'h0;
                        InstRAM_A2  <= 32'h0;
                        InstRAM_WD2 <= 32'h0;
                        state       <= IDLE;
                    end else begin
                        state <= LOAD_BYTE;
                    end
                end
                DUMP_RD: state <= DUMP_WAIT;
                DUMP_WAIT: begin
                    rdWord  <= rdSel;
                    tx_data <= rdSel[7:0];
                    byteIdx <= 2'd0;
                    state   <= DUMP_TX;
                end
                DUMP_TX: begin
                    if (tx_ready) begin
                        if (byteIdx == 2'd3) begin
                            wordIdx <= wordIdx + 13'd1;
                            if (lastWord) begin
                                DataRAM_A2 <= 32'h0;
                                InstRAM_A2 <= 32'h0;
                                state      <= IDLE;
                            end else begin
                                if (selInst) InstRAM_A2 <= nextAddr;
                                else         DataRAM_A2 <= nextAddr;
                                state <= DUMP_RD;
                            end
                        end else begin
                            byteIdx <= byteIdx + 2'd1;
                            tx_data <= rdWord[{byteIdx + 2'd1, 3'b000} +: 8];
                        end
                    end
                end
                RST_PULSE: begin
                    if (pulseCnt == '0) begin
                        state <= IDLE;
                    end else begin
                        pulseCnt <= pulseCnt - 1'b1;
                        core_rst <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_host_loader.sv
// Directed bench for ram_host_loader: load, dump, error, reset-pulse and abort sequences
// against a small BRAM model with one cycle of read latency.
module tb_ram_host_loader;
    logic        CPU_CLK;
    logic        CPU_RST;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] DataRAM_A2, DataRAM_WD2, DataRAM_RD2;
    logic [3:0]  DataRAM_WE2;
    logic [31:0] InstRAM_A2, InstRAM_WD2, InstRAM_RD2;
    logic [3:0]  InstRAM_WE2;
    logic        core_rst;
    logic        busy;
    logic        err;

    int vecs = 0;
    int miscompares = 0;

    ram_host_loader dut (
        .CPU_CLK    (CPU_CLK),
        .CPU_RST    (CPU_RST),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .DataRAM_A2 (DataRAM_A2),
        .DataRAM_WD2(DataRAM_WD2),
        .DataRAM_WE2(DataRAM_WE2),
        .DataRAM_RD2(DataRAM_RD2),
        .InstRAM_A2 (InstRAM_A2),
        .InstRAM_WD2(InstRAM_WD2),
        .InstRAM_WE2(InstRAM_WE2),
        .InstRAM_RD2(InstRAM_RD2),
        .core_rst   (core_rst),
        .busy       (busy),
        .err        (err)
    );

    initial CPU_CLK = 1'b0;
    always #5 CPU_CLK = ~CPU_CLK;

    logic [31:0] dMem [16];
    logic [31:0] iMem [16];
    logic [31:0] dWrA[$], dWrD[$], iWrA[$], iWrD[$];
    logic [7:0]  txQ[$];
    int          stallViol = 0;
    logic        prevStall = 1'b0;
    logic [7:0]  prevData = 8'h00;

    // BRAM model plus write / tx / hold-stability monitors
    always @(posedge CPU_CLK) begin
        DataRAM_RD2 <= dMem[DataRAM_A2[5:2]];
        InstRAM_RD2 <= iMem[InstRAM_A2[5:2]];
        if (DataRAM_WE2 == 4'hF) dMem[DataRAM_A2[5:2]] <= DataRAM_WD2;
        if (InstRAM_WE2 == 4'hF) iMem[InstRAM_A2[5:2]] <= InstRAM_WD2;
        if (DataRAM_WE2 != 4'h0) begin dWrA.push_back(DataRAM_A2); dWrD.push_back(DataRAM_WD2); end
        if (InstRAM_WE2 != 4'h0) begin iWrA.push_back(InstRAM_A2); iWrD.push_back(InstRAM_WD2); end
        if (tx_valid && tx_ready) txQ.push_back(tx_data);
        if (prevStall && tx_valid && (tx_data !== prevData)) stallViol++;
        prevStall <= tx_valid && !tx_ready;
        prevData  <= tx_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CPU_CLK);
        #1;
    endtask

    // Leaves rx_valid high so back-to-back bytes stream without gaps
    task automatic sendByte(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check("rx_timeout", 32'(rx_ready), 32'd1);
        tick();
    endtask

    task automatic waitIdle();
        int n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check("idle_timeout", 32'(busy), 32'd0);
    endtask

    logic [7:0] payload [8];
    logic [7:0] pat;

    initial begin
        payload = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        CPU_RST  = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b0;

        // reset
        repeat (3) tick();
        check("rst_core_rst", 32'(core_rst), 32'd1);
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_we", 32'({DataRAM_WE2, InstRAM_WE2}), 32'd0);
        check("rst_a2", DataRAM_A2 | InstRAM_A2, 32'd0);
        CPU_RST = 1'b0;
        check("rel_core_rst", 32'(core_rst), 32'd1);
        tick();
        check("post_core_rst", 32'(core_rst), 32'd0);
        check("post_rx_ready", 32'(rx_ready), 32'd1);
        check("post_busy", 32'(busy), 32'd0);

        // load data RAM, two words
        sendByte(8'h01); sendByte(8'h02); sendByte(8'h00);
        for (int i = 0; i < 4; i++) sendByte(payload[i]);
        check("ld_we0", 32'(DataRAM_WE2), 32'hF);
        check("ld_a0", DataRAM_A2, 32'h0);
        check("ld_wd0", DataRAM_WD2, 32'h12345678);
        check("ld_wr_rx_ready", 32'(rx_ready), 32'd0);
        check("ld_inst_we", 32'(InstRAM_WE2), 32'd0);
        for (int i = 4; i < 8; i++) sendByte(payload[i]);
        rx_valid = 1'b0;
        check("ld_busy_wr", 32'(busy), 32'd1);
        tick();
        check("ld_busy_done", 32'(busy), 32'd0);
        check("ld_we_done", 32'(DataRAM_WE2), 32'd0);
        check("ld_nwr", 32'(dWrA.size()), 32'd2);
        check("ld_wr0_a", dWrA[0], 32'h0);
        check("ld_wr0_d", dWrD[0], 32'h12345678);
        check("ld_wr1_a", dWrA[1], 32'h4);
        check("ld_wr1_d", dWrD[1], 32'hDEADBEEF);
        check("ld_inst_nwr", 32'(iWrA.size()), 32'd0);

        // load the same words into inst RAM
        sendByte(8'h02); sendByte(8'h02); sendByte(8'h00);
        for (int i = 0; i < 8; i++) sendByte(payload[i]);
        rx_valid = 1'b0;
        waitIdle();
        check("li_nwr", 32'(iWrA.size()), 32'd2);
        check("li_wr1_a", iWrA[1], 32'h4);
        check("li_wr1_d", iWrD[1], 32'hDEADBEEF);
        check("li_data_nwr", 32'(dWrA.size()), 32'd2);

        // dump inst RAM with tx_ready toggling
        txQ.delete();
        stallViol = 0;
        sendByte(8'h12); sendByte(8'h02); sendByte(8'h00);
        rx_valid = 1'b0;
        for (int n = 0; n < 200 && busy; n++) begin
            tx_ready = ~tx_ready;
            tick();
        end
        tx_ready = 1'b0;
        check("dp_busy", 32'(busy), 32'd0);
        check("dp_count", 32'(txQ.size()), 32'd8);
        for (int i = 0; i < 8; i++) check($sformatf("dp_byte%0d", i), 32'(txQ[i]), 32'(payload[i]));
        check("dp_stall", 32'(stallViol), 32'd0);
        check("dp_tx_valid", 32'(tx_valid), 32'd0);

        // unknown command, oversize count, zero count
        dWrA.delete(); iWrA.delete();
        sendByte(8'h33);
        rx_valid = 1'b0;
        check("bad_cmd_err", 32'(err), 32'd1);
        check("bad_cmd_busy", 32'(busy), 32'd0);
        sendByte(8'h01);
        check("cmd_clears_err", 32'(err), 32'd0);
        check("cmd_busy", 32'(busy), 32'd1);
        sendByte(8'h01); sendByte(8'h10);
        rx_valid = 1'b0;
        check("big_cnt_err", 32'(err), 32'd1);
        check("big_cnt_busy", 32'(busy), 32'd0);
        repeat (3) tick();
        check("big_cnt_nwr", 32'(dWrA.size() + iWrA.size()), 32'd0);
        sendByte(8'h01); sendByte(8'h00); sendByte(8'h00);
        rx_valid = 1'b0;
        check("zero_cnt_err", 32'(err), 32'd0);
        check("zero_cnt_busy", 32'(busy), 32'd0);
        tick();
        check("zero_cnt_nwr", 32'(dWrA.size() + iWrA.size()), 32'd0);

        // reset pulse command
        sendByte(8'h20); sendByte(8'h00); sendByte(8'h00);
        rx_valid = 1'b0;
        check("rp_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 8; i++) begin
            pat[i] = core_rst;
            tick();
        end
        check("rp_pattern", 32'(pat), 32'h1F);
        check("rp_idle", 32'(busy), 32'd0);
        check("rp_rx_ready", 32'(rx_ready), 32'd1);

        // abort a load mid-word, then a fresh single-word load
        dWrA.delete(); dWrD.delete();
        sendByte(8'h01); sendByte(8'h01); sendByte(8'h00);
        sendByte(8'hAA); sendByte(8'hBB);
        CPU_RST  = 1'b1;
        rx_valid = 1'b0;
        tick(); tick();
        check("ab_busy", 32'(busy), 32'd0);
        CPU_RST = 1'b0;
        tick();
        check("ab_nwr", 32'(dWrA.size()), 32'd0);
        sendByte(8'h01); sendByte(8'h01); sendByte(8'h00);
        sendByte(8'hAA); sendByte(8'hBB); sendByte(8'hCC); sendByte(8'hDD);
        rx_valid = 1'b0;
        check("ab_we", 32'(DataRAM_WE2), 32'hF);
        check("ab_a2", DataRAM_A2, 32'h0);
        check("ab_wd", DataRAM_WD2, 32'hDDCCBBAA);
        tick();
        check("ab_done_busy", 32'(busy), 32'd0);
        check("ab_nwr_final", 32'(dWrA.size()), 32'd1);
        check("ab_done_a2", DataRAM_A2 | DataRAM_WD2, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end
endmodule
